transmit_response_scheduler: RTL
================================

Name: transmit_response_scheduler

Overview:
- Reference-clock-domain block that sequences responses onto the UART transmitter input of the transmitter data synchronizer.
- Two response sources:
  - register-file read data: one byte.
  - ALU results: 2*DATA_WIDTH bits, sent as two bytes, low byte first.
- Holds one pending response per source and arbitrates round-robin between them.
- Runs a per-byte handshake: present data, wait for the synchronizer capture acknowledge, then wait for the transmitter busy interval to finish.

Parameters:
- DATA_WIDTH, 8, UART byte width; the ALU result width is 2*DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, reference-clock cycles allowed in WAIT_START before abort. Used only when RESPONSE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  reference clock.
- reset  input  1  asynchronous, active-low reset.
- ALU_result_valid  input  1  one-cycle pulse; ALU_result is valid.
- ALU_result  input  2*DATA_WIDTH  ALU result.
- register_file_read_data_valid  input  1  one-cycle pulse; read data is valid.
- register_file_read_data  input  DATA_WIDTH  register-file read data.
- transmitter_Q_pulse_generator  input  1  synchronized acknowledge: UART domain captured the byte.
- transmitter_busy_synchronized  input  1  synchronized transmitter busy.
- transmitter_parallel_data_valid  output  1  byte offered to the synchronizer.
- transmitter_parallel_data  output  DATA_WIDTH  byte offered.
- scheduler_busy  output  1  state is not IDLE.
- response_dropped  output  1  one-cycle pulse: an arrival was lost because its slot was full.
- timeout_error  output  1  one-cycle pulse: a byte transfer was aborted.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - Both slots empty; state IDLE; byte_index 0.
  - last_grant = ALU, so the register file wins the first tie.
- Slots:
  - alu_slot holds 2*DATA_WIDTH bits; rf_slot holds DATA_WIDTH bits; each has a full flag.
  - A valid pulse with its slot empty: capture the data and set full on the next edge.
  - A valid pulse with its slot full: discard the data, leave the slot untouched, and pulse response_dropped for 1 cycle.
  - Both valids pulsing in the same cycle: each goes to its own slot independently.
  - An arrival in the same cycle the same slot is released: the arrival is accepted, so set wins over clear.
- FSM states: IDLE, SEND, WAIT_START, WAIT_END.
  - IDLE:
    - No slot full: stay in IDLE.
    - Exactly one slot full: grant it.
    - Both full: grant the source opposite last_grant, then update last_grant.
    - On grant: byte_index = 0; go to SEND next cycle.
  - SEND:
    - transmitter_parallel_data_valid = 1.
    - transmitter_parallel_data is rf_slot, alu_slot[DATA_WIDTH-1:0] when byte_index = 0, or alu_slot[2*DATA_WIDTH-1:DATA_WIDTH] when byte_index = 1.
    - Data is registered and held stable while valid is high.
    - On transmitter_Q_pulse_generator = 1: deassert valid on the next edge and go to WAIT_START.
  - WAIT_START: go to WAIT_END when transmitter_busy_synchronized = 1.
  - WAIT_END: when transmitter_busy_synchronized = 0:
    - ALU grant with byte_index = 0: byte_index = 1, go to SEND.
    - Otherwise: release the granted slot and go to IDLE.
- Latency, measured from an arrival into an empty slot with the FSM idle:
  - slot full at +1 cycle;
  - grant decision during +1 cycle, registered at +2;
  - valid asserted at +2.
- Minimum of 1 idle cycle between responses. Back-to-back bytes of one ALU result have no IDLE cycle between them.
- A grant is never pre-empted: a slot that fills mid-transfer waits for IDLE.
- Acknowledge or busy edges arriving in states that do not expect them are ignored.
- Reset asserted mid-transfer: everything clears immediately, including any pending slot contents.

Optional Feature:
- Macro: RESPONSE_TIMEOUT_EN.
- Defined:
  - A counter, width $clog2(TIMEOUT_CYCLES+1), counts cycles spent in WAIT_START.
  - When the count reaches TIMEOUT_CYCLES: pulse timeout_error for 1 cycle, release the granted slot (remaining ALU byte discarded), go to IDLE.
  - The counter clears on every entry to WAIT_START.
- Not defined: no counter; timeout_error is tied to 0; WAIT_START waits indefinitely.

Test Plan:
- Register read: register_file_read_data = 8'hA5 pulse; ack 3 cycles later; busy high 10 cycles -> one valid with data 8'hA5, scheduler_busy returns 0 after busy falls.
- ALU result 16'h1234 pulse -> bytes 8'h34 then 8'h12; each held until its ack; slot released after the second busy fall.
- Simultaneous ALU 16'hBEEF and register 8'h5A from reset -> 8'h5A sent first, then 8'hEF, 8'hBE; a second tie afterwards grants the ALU first.
- Second register pulse 8'h11 while rf_slot is full with 8'h22 -> response_dropped pulses once; only 8'h22 is transmitted.
- Reset pulled low while in SEND with alu_slot full -> valid drops immediately; no byte is sent after release; all outputs 0.
- RESPONSE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ack given but busy never rises -> timeout_error pulses 16 cycles after entering WAIT_START; FSM returns to IDLE; the ALU high byte is never sent.

Source files
------------

// File: rtl/transmit_response_scheduler.sv
// Sequences register-file and ALU responses, one byte at a time, into the UART transmit synchronizer.
// Optional WAIT_START abort timer is enabled by defining RESPONSE_TIMEOUT_EN.
module transmit_response_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ALU_result_valid,
    input  logic [2*DATA_WIDTH-1:0]   ALU_result,
    input  logic                      register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0]     register_file_read_data,
    input  logic                      transmitter_Q_pulse_generator,
    input  logic                      transmitter_busy_synchronized,
    output logic                      transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]     transmitter_parallel_data,
    output logic                      scheduler_busy,
    output logic                      response_dropped,
    output logic                      timeout_error
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SEND       = 2'd1;
    localparam logic [1:0] WAIT_START = 2'd2;
    localparam logic [1:0] WAIT_END   = 2'd3;
    localparam int         CW         = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]              state_q, state_d;
    logic                    grant_alu_q, grant_alu_d;
    logic                    last_grant_alu_q, last_grant_alu_d;
    logic                    byte_idx_q, byte_idx_d;
    logic                    alu_full_q, alu_full_d;
    logic [2*DATA_WIDTH-1:0] alu_slot_q, alu_slot_d;
    logic                    rf_full_q, rf_full_d;
    logic [DATA_WIDTH-1:0]   rf_slot_q, rf_slot_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic                    drop_q, drop_d;
    logic                    timeout_q, timeout_d;
    logic                    release_s;
    logic                    pick_alu_s;
    logic                    expired_s;

`ifdef RESPONSE_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [CW-1:0] to_inc_s;

    // WAIT_START dwell counter, restarted on every entry into WAIT_START
    always_comb begin
        to_inc_s = to_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (state_q != WAIT_START) begin
            to_cnt_d  = {CW{1'b0}};
            expired_s = 1'b0;
        end else begin
            to_cnt_d  = to_inc_s;
            expired_s = (to_inc_s == TO_LIMIT) && !transmitter_busy_synchronized;
        end
    end

    // Timer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= {CW{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign expired_s = 1'b0;
`endif

    // Arbitration, byte handshake FSM and slot bookkeeping
    always_comb begin
        state_d          = state_q;
        grant_alu_d      = grant_alu_q;
        last_grant_alu_d = last_grant_alu_q;
        byte_idx_d       = byte_idx_q;
        tx_valid_d       = tx_valid_q;
        tx_data_d        = tx_data_q;
        timeout_d        = 1'b0;
        release_s        = 1'b0;
        pick_alu_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (alu_full_q && rf_full_q) begin
                    pick_alu_s       = !last_grant_alu_q;
                    last_grant_alu_d = !last_grant_alu_q;
                end else begin
                    pick_alu_s = alu_full_q;
                end
                if (alu_full_q || rf_full_q) begin
                    grant_alu_d = pick_alu_s;
                    byte_idx_d  = 1'b0;
                    state_d     = SEND;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = pick_alu_s ? alu_slot_q[DATA_WIDTH-1:0] : rf_slot_q;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (transmitter_Q_pulse_generator) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_START;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT_START: begin
                if (transmitter_busy_synchronized) begin
                    state_d = WAIT_END;
                end else if (expired_s) begin
                    // A stalled transmitter forfeits the whole response, including any unsent ALU byte
                    timeout_d = 1'b1;
                    release_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT_START;
                end
            end
            WAIT_END: begin
                if (transmitter_busy_synchronized) begin
                    state_d = WAIT_END;
                end else if (grant_alu_q && !byte_idx_q) begin
                    byte_idx_d = 1'b1;
                    state_d    = SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = alu_slot_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    release_s = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Arrivals beat a same-cycle release, so a freed slot can refill immediately
        alu_full_d = alu_full_q && !(release_s && grant_alu_q);
        rf_full_d  = rf_full_q && !(release_s && !grant_alu_q);
        alu_slot_d = alu_slot_q;
        rf_slot_d  = rf_slot_q;
        drop_d     = 1'b0;
        if (ALU_result_valid && !alu_full_d) begin
            alu_full_d = 1'b1;
            alu_slot_d = ALU_result;
        end else if (ALU_result_valid) begin
            drop_d = 1'b1;
        end else begin
            alu_full_d = alu_full_d;
        end
        if (register_file_read_data_valid && !rf_full_d) begin
            rf_full_d = 1'b1;
            rf_slot_d = register_file_read_data;
        end else if (register_file_read_data_valid) begin
            drop_d = 1'b1;
        end else begin
            rf_full_d = rf_full_d;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            grant_alu_q      <= 1'b0;
            last_grant_alu_q <= 1'b1;
            byte_idx_q       <= 1'b0;
            alu_full_q       <= 1'b0;
            alu_slot_q       <= {(2*DATA_WIDTH){1'b0}};
            rf_full_q        <= 1'b0;
            rf_slot_q        <= {DATA_WIDTH{1'b0}};
            tx_valid_q       <= 1'b0;
            tx_data_q        <= {DATA_WIDTH{1'b0}};
            busy_q           <= 1'b0;
            drop_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_alu_q      <= grant_alu_d;
            last_grant_alu_q <= last_grant_alu_d;
            byte_idx_q       <= byte_idx_d;
            alu_full_q       <= alu_full_d;
            alu_slot_q       <= alu_slot_d;
            rf_full_q        <= rf_full_d;
            rf_slot_q        <= rf_slot_d;
            tx_valid_q       <= tx_valid_d;
            tx_data_q        <= tx_data_d;
            busy_q           <= busy_d;
            drop_q           <= drop_d;
            timeout_q        <= timeout_d;
        end
    end

    assign transmitter_parallel_data_valid = tx_valid_q;
    assign transmitter_parallel_data       = tx_data_q;
    assign scheduler_busy                  = busy_q;
    assign response_dropped                = drop_q;
    assign timeout_error                   = timeout_q;
endmodule
